// File: rtl/magnitude_comparator_serial.sv
// ============================================================================
// magnitude_comparator_serial: compares two WIDTH-bit operands DIGIT bits per
// cycle, MSB slice first, with early exit; unsigned or two's-complement.
// Revision: 1.0
// ============================================================================
`default_nettype none

module magnitude_comparator_serial #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             a_greater,
  output logic             equal,
  output logic             b_greater
);

  localparam int NSLICE = WIDTH / DIGIT;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NSLICE - 1);

  generate
    if (DIGIT < 1 || WIDTH < DIGIT || (WIDTH % DIGIT) != 0) begin : g_param_check
      $error("magnitude_comparator_serial: WIDTH must be a non-zero multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPARE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              a_gt_q, a_gt_d;
  logic              eq_q, eq_d;
  logic              b_gt_q, b_gt_d;

  logic [DIGIT-1:0]  a_slice [NSLICE];
  logic [DIGIT-1:0]  b_slice [NSLICE];
  logic [DIGIT-1:0]  cur_a, cur_b;
  logic [WIDTH-1:0]  msb_flip;

  generate
    for (genvar g = 0; g < NSLICE; g++) begin : g_slice
      assign a_slice[g] = a_q[g*DIGIT +: DIGIT];
      assign b_slice[g] = b_q[g*DIGIT +: DIGIT];
    end
  endgenerate

  assign cur_a = a_slice[idx_q];
  assign cur_b = b_slice[idx_q];

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    idx_d    = idx_q;
    a_gt_d   = a_gt_q;
    eq_d     = eq_q;
    b_gt_d   = b_gt_q;
    // Offset-binary: flipping both sign bits lets signed compare reuse unsigned slices
    msb_flip = '0;
    msb_flip[WIDTH-1] = signed_mode;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_COMPARE;
          a_d     = a ^ msb_flip;
          b_d     = b ^ msb_flip;
          idx_d   = IDX_TOP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_COMPARE: begin
        if (cur_a != cur_b) begin
          state_d = S_DONE;
          a_gt_d  = (cur_a > cur_b);
          eq_d    = 1'b0;
          b_gt_d  = (cur_a < cur_b);
        end else if (idx_q == '0) begin
          state_d = S_DONE;
          a_gt_d  = 1'b0;
          eq_d    = 1'b1;
          b_gt_d  = 1'b0;
        end else begin
          idx_d   = idx_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      a_gt_q  <= 1'b0;
      eq_q    <= 1'b0;
      b_gt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      a_gt_q  <= a_gt_d;
      eq_q    <= eq_d;
      b_gt_q  <= b_gt_d;
    end
  end

  assign busy      = (state_q == S_COMPARE);
  assign done      = (state_q == S_DONE);
  assign a_greater = a_gt_q;
  assign equal     = eq_q;
  assign b_greater = b_gt_q;

endmodule

`default_nettype wire
